// File: rtl/decrypt_round_sequencer.sv
// Round sequencer for an iterative AES-128 inverse cipher: walks the key
// schedule 10..0 and launches an external round datapath once per round.
// Ports:
//   clk, rst              - clock, async active-high reset
//   start, abort          - begin a block (IDLE only) / cancel in flight
//   ciphertext            - input block, sampled on the accepting edge
//   key_idx, round_key    - key store request and its combinational data
//   rnd_valid, rnd_mode   - datapath launch strobe and round type
//   rnd_state_out/rnd_key - state and key presented to the datapath
//   rnd_state_in          - datapath result, ROUND_LAT cycles after launch
//   busy, done, plaintext - status, completion pulse, held result
module decrypt_round_sequencer #(
  parameter int ROUND_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] ciphertext,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         rnd_valid,
  output logic [1:0]   rnd_mode,
  output logic [127:0] rnd_state_out,
  output logic [127:0] rnd_key,
  input  logic [127:0] rnd_state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_INIT  = 2'b00;
  localparam logic [1:0] MODE_MID   = 2'b01;
  localparam logic [1:0] MODE_FINAL = 2'b10;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [1:0] LAT_LAST   = 2'(ROUND_LAT - 1);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   lat_q, lat_d;
  logic [127:0] st_q, st_d;
  logic [127:0] pt_q, pt_d;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    lat_d   = lat_q;
    st_d    = st_q;
    pt_d    = pt_q;
    unique case (state_q)
      IDLE: begin
        // start beats a simultaneous abort; abort is meaningless here
        if (start) begin
          state_d = ISSUE;
          st_d    = ciphertext;
          round_d = 4'd0;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          lat_d   = 2'd0;
        end
      end
      WAIT: begin
        // an abort drops the outstanding result on the floor
        if (abort) begin
          state_d = IDLE;
        end else if (lat_q == LAT_LAST) begin
          if (round_q == LAST_ROUND) begin
            pt_d    = rnd_state_in;
            state_d = DONE;
          end else begin
            st_d    = rnd_state_in;
            round_d = round_q + 4'd1;
            state_d = ISSUE;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      lat_q   <= 2'd0;
      st_q    <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      lat_q   <= lat_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
    end
  end

  logic active;
  assign active = (state_q == ISSUE) || (state_q == WAIT);

  always_comb begin
    rnd_mode = MODE_MID;
    unique case (1'b1)
      (round_q == 4'd0):       rnd_mode = MODE_INIT;
      (round_q == LAST_ROUND): rnd_mode = MODE_FINAL;
      default:                 rnd_mode = MODE_MID;
    endcase
  end

  // key schedule is consumed in reverse for decryption
  assign key_idx       = active ? (LAST_ROUND - round_q) : 4'd0;
  assign rnd_valid     = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign rnd_state_out = st_q;
  assign rnd_key       = round_key;
  assign plaintext     = pt_q;

endmodule

// File: tb/tb_decrypt_round_sequencer.sv
// Directed bench for decrypt_round_sequencer: real inverse-AES datapath
// and XOR stub at ROUND_LAT 1, XOR stub at ROUND_LAT 3.
module tb_decrypt_round_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic         abort_a = 1'b0;
  logic         abort_b = 1'b0;
  logic [127:0] ciphertext = '0;
  logic         aes_mode = 1'b0;

  logic [3:0]   key_idx_a, key_idx_b;
  logic         rnd_valid_a, rnd_valid_b;
  logic [1:0]   rnd_mode_a, rnd_mode_b;
  logic [127:0] rnd_state_out_a, rnd_state_out_b;
  logic [127:0] rnd_key_a, rnd_key_b;
  logic [127:0] rnd_state_in_a, rnd_state_in_b;
  logic         busy_a, busy_b, done_a, done_b;
  logic [127:0] plaintext_a, plaintext_b;

  logic [127:0] rk [0:15];
  logic [7:0]   sb [0:255];
  logic [7:0]   isb [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decrypt_round_sequencer #(.ROUND_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .ciphertext(ciphertext), .key_idx(key_idx_a),
    .round_key(rk[key_idx_a]), .rnd_valid(rnd_valid_a),
    .rnd_mode(rnd_mode_a), .rnd_state_out(rnd_state_out_a),
    .rnd_key(rnd_key_a), .rnd_state_in(rnd_state_in_a),
    .busy(busy_a), .done(done_a), .plaintext(plaintext_a)
  );

  decrypt_round_sequencer #(.ROUND_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .ciphertext(ciphertext), .key_idx(key_idx_b),
    .round_key(rk[key_idx_b]), .rnd_valid(rnd_valid_b),
    .rnd_mode(rnd_mode_b), .rnd_state_out(rnd_state_out_b),
    .rnd_key(rnd_key_b), .rnd_state_in(rnd_state_in_b),
    .busy(busy_b), .done(done_b), .plaintext(plaintext_b)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic [1:0] m);
    logic [127:0] x;
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    x = s ^ k;
    if (m != 2'b00 && m != 2'b01) return x;
    for (int i = 0; i < 16; i++) b[i] = x[127-8*i -: 8];
    if (m == 2'b01) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
        b[4*c+1] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
        b[4*c+2] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
        b[4*c+3] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r + 4*((c + r) % 4)] = isb[b[r + 4*c]];
    for (int i = 0; i < 16; i++) x[127-8*i -: 8] = t[i];
    return x;
  endfunction

  function automatic logic [127:0] xor_all();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i <= 10; i++) v = v ^ rk[i];
    return v;
  endfunction

  // round datapath models
  logic [127:0] dp_a, b1, b2, b3;
  always @(posedge clk) begin
    if (rnd_valid_a)
      dp_a <= aes_mode ? inv_round(rnd_state_out_a, rnd_key_a, rnd_mode_a)
                       : (rnd_state_out_a ^ rnd_key_a);
    if (rnd_valid_b) b1 <= rnd_state_out_b ^ rnd_key_b;
    b2 <= b1;
    b3 <= b2;
  end
  assign rnd_state_in_a = dp_a;
  assign rnd_state_in_b = b3;

  // event monitors
  int vcnt_a = 0, vcnt_b = 0, dcnt_a = 0, pchg_a = 0;
  logic [3:0] kseq [0:1023];
  logic [1:0] mseq [0:1023];
  logic [127:0] pt_prev = '0;
  always @(negedge clk) begin
    if (rnd_valid_a) begin
      kseq[vcnt_a[9:0]] <= key_idx_a;
      mseq[vcnt_a[9:0]] <= rnd_mode_a;
      vcnt_a <= vcnt_a + 1;
    end
    if (rnd_valid_b) vcnt_b <= vcnt_b + 1;
    if (done_a) dcnt_a <= dcnt_a + 1;
    if (plaintext_a !== pt_prev) pchg_a <= pchg_a + 1;
    pt_prev <= plaintext_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [127:0] ct, output int lat,
                       output logic [127:0] pt);
    ciphertext = ct;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 200) begin
      tick();
      lat++;
    end
    pt = plaintext_a;
  endtask

  task automatic build_tables();
    logic [7:0] v, inv, s, rc;
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [127:0] key;
    for (int x = 0; x < 256; x++) begin
      v = 8'(x);
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, v);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
      isb[s] = v;
    end
    key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (busy_a !== 1'b0) begin fails++;
      $display("FAIL reset_busy got %b want 0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++;
      $display("FAIL reset_done got %b want 0", done_a); end
    tests++; if (rnd_valid_a !== 1'b0) begin fails++;
      $display("FAIL reset_rnd_valid got %b want 0", rnd_valid_a); end
    tests++; if (rnd_mode_a !== 2'b00) begin fails++;
      $display("FAIL reset_rnd_mode got %b want 00", rnd_mode_a); end
    tests++; if (key_idx_a !== 4'd0) begin fails++;
      $display("FAIL reset_key_idx got %0d want 0", key_idx_a); end
    tests++; if (rnd_state_out_a !== 128'h0) begin fails++;
      $display("FAIL reset_state_out got %h want 0", rnd_state_out_a); end
    tests++; if (plaintext_a !== 128'h0) begin fails++;
      $display("FAIL reset_plaintext got %h want 0", plaintext_a); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    int lat, base;
    logic [127:0] pt;
    aes_mode = 1'b1;
    base = vcnt_a;
    run_a(128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat, pt);
    tests++; if (lat !== 22) begin fails++;
      $display("FAIL fips_latency got %0d want 22", lat); end
    tests++; if (pt !== 128'h00112233445566778899aabbccddeeff) begin fails++;
      $display("FAIL fips_plaintext got %h want 00112233445566778899aabbccddeeff", pt); end
    tests++; if (vcnt_a - base !== 11) begin fails++;
      $display("FAIL fips_strobes got %0d want 11", vcnt_a - base); end
    tick();
  endtask

  task automatic test_sequence();
    int lat, base;
    logic [127:0] pt, ct, exp;
    logic [1:0] m;
    aes_mode = 1'b0;
    ct = 128'h0123456789abcdeffedcba9876543210;
    exp = ct ^ xor_all();
    base = vcnt_a;
    run_a(ct, lat, pt);
    tests++; if (pt !== exp) begin fails++;
      $display("FAIL seq_plaintext got %h want %h", pt, exp); end
    tests++; if (lat !== 22) begin fails++;
      $display("FAIL seq_latency got %0d want 22", lat); end
    tests++; if (vcnt_a - base !== 11) begin fails++;
      $display("FAIL seq_strobes got %0d want 11", vcnt_a - base); end
    for (int i = 0; i <= 10; i++) begin
      m = (i == 0) ? 2'b00 : ((i == 10) ? 2'b10 : 2'b01);
      tests++; if (kseq[base + i] !== 4'(10 - i)) begin fails++;
        $display("FAIL seq_key_idx[%0d] got %0d want %0d", i,
                 kseq[base + i], 10 - i); end
      tests++; if (mseq[base + i] !== m) begin fails++;
        $display("FAIL seq_mode[%0d] got %b want %b", i,
                 mseq[base + i], m); end
    end
    ct = 128'hdeadbeef00000000cafef00d12345678;
    exp = ct ^ xor_all();
    base = vcnt_b;
    ciphertext = ct;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 200) begin
      tick();
      lat++;
    end
    tests++; if (lat !== 44) begin fails++;
      $display("FAIL lat3_latency got %0d want 44", lat); end
    tests++; if (plaintext_b !== exp) begin fails++;
      $display("FAIL lat3_plaintext got %h want %h", plaintext_b, exp); end
    tests++; if (vcnt_b - base !== 11) begin fails++;
      $display("FAIL lat3_strobes got %0d want 11", vcnt_b - base); end
    tick();
  endtask

  task automatic test_start_while_busy();
    int d0, c0, n;
    logic [127:0] ct, exp;
    ct = 128'h11112222333344445555666677778888;
    exp = ct ^ xor_all();
    d0 = dcnt_a;
    c0 = pchg_a;
    ciphertext = ct;
    start_a = 1'b1;
    tick();
    ciphertext = 128'hffffffff00000000ffffffff00000000;
    n = 0;
    while (!done_a && n < 200) begin
      tick();
      n++;
    end
    tests++; if (plaintext_a !== exp) begin fails++;
      $display("FAIL busy_plaintext got %h want %h", plaintext_a, exp); end
    tick();
    start_a = 1'b0;
    tests++; if (busy_a !== 1'b0) begin fails++;
      $display("FAIL done_start_accepted busy got %b want 0", busy_a); end
    repeat (30) tick();
    tests++; if (dcnt_a - d0 !== 1) begin fails++;
      $display("FAIL busy_done_count got %0d want 1", dcnt_a - d0); end
    tests++; if (pchg_a - c0 !== 1) begin fails++;
      $display("FAIL busy_pt_changes got %0d want 1", pchg_a - c0); end
  endtask

  task automatic test_abort();
    int d0, lat;
    logic [127:0] prev, ct, pt, exp;
    ct = 128'h5a5a5a5aa5a5a5a50f0f0f0ff0f0f0f0;
    exp = ct ^ xor_all();
    prev = plaintext_a;
    d0 = dcnt_a;
    ciphertext = ct;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (11) tick();
    tests++; if ({rnd_valid_a, key_idx_a, rnd_mode_a} !== {1'b0, 4'd5, 2'b01})
      begin fails++;
      $display("FAIL abort_at_r5_wait got v=%b k=%0d m=%b want v=0 k=5 m=01",
               rnd_valid_a, key_idx_a, rnd_mode_a); end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    tests++; if (busy_a !== 1'b0) begin fails++;
      $display("FAIL abort_busy got %b want 0", busy_a); end
    repeat (30) tick();
    tests++; if (dcnt_a !== d0) begin fails++;
      $display("FAIL abort_done_count got %0d want %0d", dcnt_a, d0); end
    tests++; if (plaintext_a !== prev) begin fails++;
      $display("FAIL abort_plaintext got %h want %h", plaintext_a, prev); end
    run_a(ct, lat, pt);
    tests++; if (pt !== exp || lat !== 22) begin fails++;
      $display("FAIL abort_rerun got %h lat %0d want %h lat 22",
               pt, lat, exp); end
    tick();
  endtask

  task automatic test_async_reset();
    int d0, lat;
    logic [127:0] ct, pt, exp;
    ct = 128'h00000000000000000000000000000001;
    exp = ct ^ xor_all();
    ciphertext = ct;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    tests++; if (busy_a !== 1'b0) begin fails++;
      $display("FAIL arst_busy got %b want 0", busy_a); end
    tests++; if (plaintext_a !== 128'h0) begin fails++;
      $display("FAIL arst_plaintext got %h want 0", plaintext_a); end
    @(negedge clk);
    rst = 1'b0;
    d0 = dcnt_a;
    repeat (30) tick();
    tests++; if (dcnt_a !== d0) begin fails++;
      $display("FAIL arst_done_count got %0d want %0d", dcnt_a, d0); end
    run_a(ct, lat, pt);
    tests++; if (pt !== exp || lat !== 22) begin fails++;
      $display("FAIL arst_rerun got %h lat %0d want %h lat 22",
               pt, lat, exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [127:0] ct1, ct2, e1, e2;
    ct1 = 128'hcafebabecafebabecafebabecafebabe;
    ct2 = 128'h0badf00d0badf00d0badf00d0badf00d;
    e1 = ct1 ^ xor_all();
    e2 = ct2 ^ xor_all();
    ciphertext = ct1;
    start_a = 1'b1;
    tick();
    ciphertext = ct2;
    n = 0;
    while (!done_a && n < 200) begin
      tick();
      n++;
    end
    tests++; if (n !== 22 || plaintext_a !== e1) begin fails++;
      $display("FAIL b2b_first got %h lat %0d want %h lat 22",
               plaintext_a, n, e1); end
    tick();
    tests++; if (busy_a !== 1'b0) begin fails++;
      $display("FAIL b2b_idle_gap busy got %b want 0", busy_a); end
    tick();
    start_a = 1'b0;
    tests++; if (busy_a !== 1'b1) begin fails++;
      $display("FAIL b2b_second_accept busy got %b want 1", busy_a); end
    n = 0;
    while (!done_a && n < 200) begin
      tick();
      n++;
    end
    tests++; if (n !== 22 || plaintext_a !== e2) begin fails++;
      $display("FAIL b2b_second got %h lat %0d want %h lat 22",
               plaintext_a, n, e2); end
    tick();
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_sequence();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decrypt_round_sequencer.md
DECRYPT_ROUND_SEQUENCER -- requirements
Module: decrypt_round_sequencer

Interface
REQ-001 Parameter: ROUND_LAT, default 1, cycles from rnd_valid to rnd_state_in valid in the round datapath; legal range 1..4.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to decrypt ciphertext; accepted only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 ciphertext  input  128  block to decrypt; sampled on the accepting edge only.
REQ-007 key_idx  output  4  round-key index requested from the key store.
REQ-008 round_key  input  128  key store data for key_idx, valid combinationally in the same cycle.
REQ-009 rnd_valid  output  1  one-cycle strobe that launches the round datapath.
REQ-010 rnd_mode  output  2  round type: 00 INIT (ARK, ISR, ISB), 01 MID (ARK, IMC, ISR, ISB), 10 FINAL (ARK only); 11 is never driven.
REQ-011 rnd_state_out  output  128  state presented to the round datapath (registered).
REQ-012 rnd_key  output  128  round key presented to the datapath, equal to round_key.
REQ-013 rnd_state_in  input  128  datapath result, valid ROUND_LAT cycles after rnd_valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; plaintext is valid in that cycle.
REQ-016 plaintext  output  128  final result, held until the next accepted start.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-018 Transitions:
- IDLE to ISSUE on start.
- ISSUE to WAIT after 1 cycle.
- WAIT to ISSUE after ROUND_LAT cycles if round < 10.
- WAIT to DONE after ROUND_LAT cycles if round = 10.
- DONE to IDLE after 1 cycle.
REQ-019 Accepting edge: ciphertext is loaded into the state register, the round counter is cleared to 0 and plaintext is left unchanged.
REQ-020 Round counter, 4 bits, counts 0..10; key_idx = 10 - round in ISSUE and WAIT, and 0 in IDLE and DONE.
REQ-021 rnd_mode: INIT when round = 0, MID when round = 1..9, FINAL when round = 10.
REQ-022 rnd_valid is high for exactly the ISSUE cycle, once per round, giving 11 strobes per block.
REQ-023 Last WAIT cycle of each round: rnd_state_in is captured into the state register and the round counter increments, except after round 10.
REQ-024 Round-10 capture: rnd_state_in is written to plaintext, and done = 1 in the following DONE cycle.
REQ-025 Latency: done is high in the cycle beginning 11*(1+ROUND_LAT) edges after the accepting edge (22 edges for ROUND_LAT = 1); throughput is one block per 11*(1+ROUND_LAT)+2 cycles.
REQ-026 start while busy (ISSUE, WAIT or DONE) is ignored, with no queueing.
REQ-027 start in the same cycle that DONE returns to IDLE is not accepted; start must be high in IDLE.
REQ-028 abort in ISSUE or WAIT: the next state is IDLE, there is no done pulse, plaintext is unchanged, and any rnd_state_in still outstanding is discarded.
REQ-029 abort in IDLE or DONE has no effect, and the DONE pulse still completes.
REQ-030 abort and start high together in IDLE: start wins and the block is accepted.
REQ-031 Outputs other than rnd_key come from registers or from decoding the FSM state and round counter.

Reset
REQ-032 Asserting rst at any time, including mid-operation, forces IDLE immediately, with no done pulse for the interrupted block.
REQ-033 Reset values:
- busy = 0, done = 0, rnd_valid = 0.
- rnd_mode = 00, key_idx = 0, round counter = 0.
- rnd_state_out = 0, plaintext = 0.
REQ-034 After rst deasserts, the first start accepted in IDLE proceeds normally.

Verification
REQ-035 FIPS-197 vector: key store holds the expanded key of 000102030405060708090a0b0c0d0e0f, real round datapath with ROUND_LAT = 1, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, with done 22 edges after the accepting edge.
REQ-036 Sequencing check with a stub datapath that returns state XOR key -> key_idx sequence 10,9,...,0, rnd_mode sequence 00, 01 x9, 10, exactly 11 rnd_valid pulses; repeat with ROUND_LAT = 3 -> done 44 edges after accept.
REQ-037 start pulsed on every cycle while busy -> exactly one done; plaintext changes only once.
REQ-038 abort asserted in the WAIT of round 5 -> IDLE on the next edge, no done, plaintext keeps its previous value; a new start then completes correctly.
REQ-039 rst asserted asynchronously mid-WAIT (between edges) -> busy = 0 and plaintext = 0 before the next clk edge, and no done pulse.
REQ-040 Back-to-back blocks with start held high -> second accept occurs one cycle after done (the IDLE cycle), and both plaintexts are correct.
